// File: rtl/ccr_if.sv
// Bus bundle between the 68k-style condition-code unit and its surroundings:
// ALU flag updates, direct CCR writes, condition evaluation and DBcc handshake.
interface ccr_if #(parameter int bits = 16);
    logic            c, z, v, n;
    logic [4:0]      upd;
    logic            wr_en;
    logic [1:0]      wr_op;
    logic [4:0]      wr_data;
    logic [3:0]      cond;
    logic            cond_valid;
    logic            cond_true;
    logic            cond_done;
    logic [4:0]      ccr;
    logic            x;
    logic            db_start;
    logic [3:0]      db_cond;
    logic [bits-1:0] db_cnt_in;
    logic            db_busy;
    logic            db_done;
    logic            db_branch;
    logic [bits-1:0] db_cnt_out;

    modport master (
        output c, z, v, n, upd, wr_en, wr_op, wr_data, cond, cond_valid,
               db_start, db_cond, db_cnt_in,
        input  cond_true, cond_done, ccr, x, db_busy, db_done, db_branch, db_cnt_out
    );

    modport slave (
        input  c, z, v, n, upd, wr_en, wr_op, wr_data, cond, cond_valid,
               db_start, db_cond, db_cnt_in,
        output cond_true, cond_done, ccr, x, db_busy, db_done, db_branch, db_cnt_out
    );
endinterface

// File: rtl/ccr_unit.sv
// Condition code register {X,N,Z,V,C} with ALU/direct-write update, condition
// evaluation, and an optional DBcc sequencer compiled in with CCR_DBCC_EN.
module ccr_unit #(
    parameter int bits = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    ccr_if.slave   bus
);

    function automatic logic cc_eval(input logic [3:0] cc, input logic [4:0] f);
        logic fn, fz, fv, fc;
        fn = f[3]; fz = f[2]; fv = f[1]; fc = f[0];
        case (cc)
            4'h0: cc_eval = 1'b1;
            4'h1: cc_eval = 1'b0;
            4'h2: cc_eval = !fc && !fz;
            4'h3: cc_eval = fc || fz;
            4'h4: cc_eval = !fc;
            4'h5: cc_eval = fc;
            4'h6: cc_eval = !fz;
            4'h7: cc_eval = fz;
            4'h8: cc_eval = !fv;
            4'h9: cc_eval = fv;
            4'hA: cc_eval = !fn;
            4'hB: cc_eval = fn;
            4'hC: cc_eval = (fn == fv);
            4'hD: cc_eval = (fn != fv);
            4'hE: cc_eval = !fz && (fn == fv);
            default: cc_eval = fz || (fn != fv);
        endcase
    endfunction

    logic [4:0] ccr_q, ccr_d;
    logic       cond_true_q, cond_true_d;
    logic       cond_done_q, cond_done_d;
    logic [4:0] alu_flags;

    // X takes the carry, so the ALU word repeats c in the top position.
    assign alu_flags = {bus.c, bus.n, bus.z, bus.v, bus.c};

    always_comb begin
        ccr_d = ccr_q;
        if (bus.wr_en) begin
            case (bus.wr_op)
                2'b00:   ccr_d = bus.wr_data;
                2'b01:   ccr_d = ccr_q & bus.wr_data;
                2'b10:   ccr_d = ccr_q | bus.wr_data;
                default: ccr_d = ccr_q ^ bus.wr_data;
            endcase
        end else begin
            for (int i = 0; i < 5; i++)
                if (bus.upd[i]) ccr_d[i] = alu_flags[i];
        end
    end

    always_comb begin
        cond_done_d = bus.cond_valid;
        cond_true_d = cond_true_q;
        if (bus.cond_valid) cond_true_d = cc_eval(bus.cond, ccr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_q       <= '0;
            cond_true_q <= 1'b0;
            cond_done_q <= 1'b0;
        end else begin
            ccr_q       <= ccr_d;
            cond_true_q <= cond_true_d;
            cond_done_q <= cond_done_d;
        end
    end

    assign bus.ccr       = ccr_q;
    assign bus.x         = ccr_q[4];
    assign bus.cond_true = cond_true_q;
    assign bus.cond_done = cond_done_q;

`ifdef CCR_DBCC_EN
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} db_state_e;

    db_state_e       state_q, state_d;
    logic [3:0]      db_cond_q, db_cond_d;
    logic [bits-1:0] db_cnt_q, db_cnt_d;
    logic            db_branch_q, db_branch_d;
    logic [bits-1:0] db_dec;

    assign db_dec = db_cnt_q - bits'(1);

    always_comb begin
        state_d     = state_q;
        db_cond_d   = db_cond_q;
        db_cnt_d    = db_cnt_q;
        db_branch_d = db_branch_q;
        case (state_q)
            S_IDLE: begin
                if (bus.db_start) begin
                    db_cond_d = bus.db_cond;
                    db_cnt_d  = bus.db_cnt_in;
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                if (cc_eval(db_cond_q, ccr_q)) begin
                    db_branch_d = 1'b0;
                end else begin
                    db_cnt_d    = db_dec;
                    // Counter expiring to -1 terminates the loop: fall through.
                    db_branch_d = ~&db_dec;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            db_cond_q   <= '0;
            db_cnt_q    <= '0;
            db_branch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cond_q   <= db_cond_d;
            db_cnt_q    <= db_cnt_d;
            db_branch_q <= db_branch_d;
        end
    end

    assign bus.db_busy    = (state_q != S_IDLE);
    assign bus.db_done    = (state_q == S_DONE);
    assign bus.db_branch  = db_branch_q;
    assign bus.db_cnt_out = db_cnt_q;
`else
    logic db_unused;
    assign db_unused      = ^{bus.db_start, bus.db_cond, bus.db_cnt_in};
    assign bus.db_busy    = 1'b0;
    assign bus.db_done    = 1'b0;
    assign bus.db_branch  = 1'b0;
    assign bus.db_cnt_out = '0;
`endif

endmodule

// File: doc/ccr_unit.md
CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have parameter: bits, 16, DBcc counter width.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: c, z, v, n  in  1 each  ALU flag outputs.
REQ-005 SHALL have port: upd  in  5  per-flag ALU update enable, bit order {X,N,Z,V,C}; X loads from c.
REQ-006 SHALL have ports: wr_en  in  1; wr_op  in  2 (00 move, 01 and, 10 or, 11 eor); wr_data  in  5  direct CCR write.
REQ-007 SHALL have ports: cond  in  4  68k condition code; cond_valid  in  1  evaluate request.
REQ-008 SHALL have ports: cond_true  out  1; cond_done  out  1  one-cycle result strobe.
REQ-009 SHALL have ports: ccr  out  5  {X,N,Z,V,C}; x  out  1  = ccr[4], feeds ALU x input.
REQ-010 SHALL have ports: db_start  in  1; db_cond  in  4; db_cnt_in  in  bits; db_busy  out  1; db_done  out  1; db_branch  out  1; db_cnt_out  out  bits.

Function
REQ-011 SHALL update each CCR bit from the ALU on a rising edge when its upd bit is 1; bits with upd 0 hold.
REQ-012 SHALL apply wr_op on wr_data to all five CCR bits when wr_en=1; wr_en overrides upd in the same cycle.
REQ-013 SHALL evaluate conditions: 0 T, 1 F, 2 HI !C&!Z, 3 LS C|Z, 4 CC !C, 5 CS C, 6 NE !Z, 7 EQ Z, 8 VC !V, 9 VS V, A PL !N, B MI N, C GE N==V, D LT N!=V, E GT !Z&(N==V), F LE Z|(N!=V).
REQ-014 SHALL register cond_true and pulse cond_done one cycle after cond_valid, using the CCR value before that edge's update.
REQ-015 SHALL implement DBcc FSM IDLE->EVAL->DONE->IDLE; db_start in IDLE latches db_cond, db_cnt_in; db_busy=1 in EVAL and DONE.
REQ-016 SHALL in EVAL test db_cond on current CCR: true -> count unchanged, branch 0; false -> count-1 mod 2^bits, branch 1 unless result is all-ones.
REQ-017 SHALL pulse db_done for one cycle in DONE, with db_branch and db_cnt_out valid then and held until next db_start.
REQ-018 SHALL ignore db_start while db_busy=1.
REQ-019 SHALL let cond path and DBcc run concurrently without interaction.

Reset
REQ-020 SHALL on rst_n=0 immediately force ccr=0, x=0, cond_true=0, cond_done=0, db_busy=0, db_done=0, db_branch=0, db_cnt_out=0, FSM to IDLE, including mid-DBcc.
REQ-021 SHALL resume operation on the first rising edge after rst_n deasserts.

Configuration
REQ-022 SHALL compile the DBcc FSM only when CCR_DBCC_EN is defined; without it db_busy, db_done, db_branch, db_cnt_out tie to 0 and db_start is ignored.

Verification
REQ-023 Reset: rst_n=0 mid-EVAL -> all outputs 0 immediately, FSM IDLE.
REQ-024 ALU update: upd=11111, c=1 z=0 v=1 n=1 -> ccr=11011, x=1; then upd=00100, z=1 -> ccr=11111.
REQ-025 Write priority: wr_en=1, wr_op=01, wr_data=00100, upd=11111 same cycle, ccr was 11111 -> ccr=00100.
REQ-026 Conditions: ccr N=1,V=0 -> cond=C gives 0, D gives 1; ccr Z=1 -> cond=E gives 0, F gives 1, strobe exactly one cycle later.
REQ-027 DBcc: db_cond=1 (F), db_cnt_in=0x0001 -> db_cnt_out=0x0000, db_branch=1; db_cnt_in=0x0000 -> 0xFFFF, db_branch=0; db_cond=0 -> count unchanged, db_branch=0; db_done two cycles after start.
REQ-028 Busy: second db_start during EVAL -> ignored, single db_done.
